// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Serialises one DATA_BITS-wide word per frame onto an
//   idle-high line: start bit (0), data LSB first, optional parity bit, then
//   STOP_BITS high stop bits. Bit timing is driven entirely by baud_tick, a
//   one-clock strobe from the baud generator; one strobe = one bit period.
//   A one-entry pending register lets the next word be accepted during the
//   final stop bit so consecutive frames run with no idle gap.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   baud_tick  bit-period strobe
//   tx_data    word to send, captured on the handshake edge
//   tx_valid   tx_data is valid
//   tx_ready   block can accept tx_data this cycle (combinational)
//   tx         serial line, idle high (registered)
//   tx_busy    a frame is armed or in progress (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_pend_vld;
  logic [DATA_BITS-1:0] r_pend_data;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_last_stop;
  logic                 w_last_data;
  logic                 w_xfer;
  logic                 w_close;
  logic                 w_load_idle;
  logic                 w_restart;
  logic                 w_fill_pend;
  logic [DATA_BITS-1:0] w_next_word;

  // Parity of a whole word; only meaningful when PARITY != 0.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
  assign tx_ready    = (r_state == S_IDLE) | (w_last_stop & ~r_pend_vld);
  assign w_xfer      = tx_valid & tx_ready;
  assign w_close     = w_last_stop & baud_tick;
  assign w_load_idle = (r_state == S_IDLE) & w_xfer;
  // A word accepted on the closing tick itself goes straight into the shift
  // register, exactly as if it had passed through the pending slot.
  assign w_restart   = w_close & (r_pend_vld | w_xfer);
  assign w_fill_pend = w_last_stop & w_xfer & ~baud_tick;
  assign w_next_word = r_pend_vld ? r_pend_data : tx_data;

  // Datapath registers: contents are qualified by the control state, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (w_load_idle) begin
      r_shift <= tx_data;
      r_par   <= f_parity(tx_data);
    end else if (w_restart) begin
      r_shift <= w_next_word;
      r_par   <= f_parity(w_next_word);
    end else if ((r_state == S_DATA) && baud_tick && !w_last_data) begin
      r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
    end
    if (w_fill_pend) begin
      r_pend_data <= tx_data;
    end
  end

  // Frame sequencer. r_shift[0] always holds the data bit currently on the
  // line while in DATA, so the next bit to drive is r_shift[1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_pend_vld <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      if (w_fill_pend) begin
        r_pend_vld <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // baud_tick is deliberately ignored here, even on the transfer edge.
          if (w_xfer) begin
            r_state <= S_ARMED;
            tx_busy <= 1'b1;
          end
        end
        S_ARMED: begin
          if (baud_tick) begin
            tx      <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx        <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (w_last_data) begin
              if (PARITY != 0) begin
                tx      <= r_par;
                r_state <= S_PARITY;
              end else begin
                tx         <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              tx        <= r_shift[1];
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx         <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (w_last_stop) begin
              if (r_pend_vld | w_xfer) begin
                // Gapless: next start bit begins on this very tick.
                tx         <= 1'b0;
                r_pend_vld <= 1'b0;
                r_state    <= S_START;
              end else begin
                tx_busy <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx. Four instances cover 8N1, 8E1, 8O1 and 7N2. A free
//   running baud strobe fires every 16 clocks. Expected line levels come from
//   a frame model that lists the bits of each frame (start, data LSB first,
//   parity from a ones count, stop bits); the line is sampled mid-bit.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] dat  [4];
  logic       vld  [4];
  logic       rdy  [4];
  logic       txl  [4];
  logic       busy [4];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   tcnt     = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  // Baud strobe: one clock high out of every 16, set up on the falling edge.
  always @(negedge clk) begin
    tcnt      = (tcnt == 15) ? 0 : tcnt + 1;
    baud_tick = (tcnt == 15);
  end

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[0]),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[1]),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[2]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]));
  uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[3][6:0]),
    .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]));

  function automatic int nbits(int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int pmode(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int nstop(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All bench activity happens 1 ns after a falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Frame model: append the expected line bits of one frame for instance i.
  task automatic add_frame(input int i, input logic [7:0] d);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int k = 0; k < nbits(i); k++) begin
      exp_q.push_back(d[k]);
      ones += int'(d[k]);
    end
    if (pmode(i) == 2) exp_q.push_back(1'((ones % 2) != 0));
    if (pmode(i) == 1) exp_q.push_back(1'((ones % 2) == 0));
    for (int k = 0; k < nstop(i); k++) exp_q.push_back(1'b1);
  endtask

  // Offer a word with tx_valid held until accepted, then scramble tx_data.
  task automatic push(input int i, input logic [7:0] d);
    int n;
    n      = 0;
    dat[i] = d;
    vld[i] = 1'b1;
    while (!rdy[i] && n < 2000) begin
      step();
      n++;
    end
    check_eq("ready_wait", 32'(n < 2000), 32'd1);
    step();
    vld[i] = 1'b0;
    dat[i] = 8'($urandom);
  endtask

  // Wait for the first start bit, then compare every expected bit mid-bit
  // with no gaps, then confirm busy drops on the closing tick.
  task automatic check_stream(input int i, input string tag);
    int n;
    n = 0;
    while (txl[i] !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    check_eq({tag, "_start_wait"}, 32'(n < 2000), 32'd1);
    repeat (8) step();
    for (int k = 0; k < exp_q.size(); k++) begin
      check_eq($sformatf("%s_bit%0d", tag, k), 32'(txl[i]), 32'(exp_q[k]));
      if (k < exp_q.size() - 1) repeat (16) step();
    end
    repeat (7) step();
    check_eq({tag, "_busy_before_close"}, 32'(busy[i]), 32'd1);
    step();
    check_eq({tag, "_busy_after_close"}, 32'(busy[i]), 32'd0);
    check_eq({tag, "_ready_after_close"}, 32'(rdy[i]), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rd [3];
    int         nfr;
    int         n;
    int         cnt;

    for (int i = 0; i < 4; i++) begin
      dat[i] = '0;
      vld[i] = 1'b0;
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_tx%0d", i), 32'(txl[i]), 32'd1);
      check_eq($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      check_eq($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // 8N1 0xA5
    add_frame(0, 8'hA5);
    fork
      push(0, 8'hA5);
      check_stream(0, "t1_8n1_a5");
    join

    // Parity: even and odd on 0xA5, even on 0x07
    add_frame(1, 8'hA5);
    fork
      push(1, 8'hA5);
      check_stream(1, "t2_even_a5");
    join
    add_frame(2, 8'hA5);
    fork
      push(2, 8'hA5);
      check_stream(2, "t2_odd_a5");
    join
    add_frame(1, 8'h07);
    fork
      push(1, 8'h07);
      check_stream(1, "t2_even_07");
    join

    // Back-to-back frames must run gapless
    add_frame(0, 8'h55);
    add_frame(0, 8'hAA);
    fork
      begin
        push(0, 8'h55);
        push(0, 8'hAA);
      end
      check_stream(0, "t3_b2b");
    join

    // Transfer on the same edge as a baud tick while idle
    n = 0;
    while (baud_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("t4_tick_align", 32'(n < 40), 32'd1);
    push(0, 8'h5A);
    n   = 0;
    cnt = 0;
    while (txl[0] === 1'b1 && n < 100) begin
      step();
      n++;
      if (rdy[0]) cnt++;
    end
    check_eq("t4_start_latency", 32'(n), 32'd16);
    check_eq("t4_ready_low_armed", 32'(cnt), 32'd0);
    n = 0;
    while (busy[0] && n < 400) begin
      step();
      n++;
    end
    check_eq("t4_frame_done", 32'(n < 400), 32'd1);

    // Reset in the middle of data bit 3
    fork
      push(0, 8'hA5);
      begin
        n = 0;
        while (txl[0] !== 1'b0 && n < 2000) begin
          step();
          n++;
        end
        check_eq("t5_start_wait", 32'(n < 2000), 32'd1);
        repeat (72) step();
        check_eq("t5_bit3_pre", 32'(txl[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx", 32'(txl[0]), 32'd1);
        check_eq("t5_rst_ready", 32'(rdy[0]), 32'd1);
        check_eq("t5_rst_busy", 32'(busy[0]), 32'd0);
      end
    join
    repeat (3) step();
    rst_n = 1'b1;
    step();
    add_frame(0, 8'h3C);
    fork
      push(0, 8'h3C);
      check_stream(0, "t5_after_3c");
    join

    // 7N2 0x7F, then no transfer while tx_valid stays low
    add_frame(3, 8'h7F);
    fork
      push(3, 8'h7F);
      check_stream(3, "t6_7n2_7f");
    join
    cnt = 0;
    repeat (40) begin
      step();
      if (txl[3] && !busy[3]) cnt++;
    end
    check_eq("t6_stay_idle", 32'(cnt), 32'd40);

    // Randomized bursts of 1..3 gapless frames on every instance
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        nfr = int'($urandom_range(1, 3));
        for (int k = 0; k < nfr; k++) begin
          rd[k] = 8'($urandom);
          add_frame(i, rd[k]);
        end
        fork
          begin
            for (int k = 0; k < nfr; k++) push(i, rd[k]);
          end
          check_stream(i, $sformatf("rnd%0d_u%0d", r, i));
        join
        repeat (int'($urandom_range(0, 20))) step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
